// File: rtl/if_id_issue_buffer_pkg.sv
// Shared IF/ID definitions: default bundle geometry, the NOP encoding and the
// packed-bundle field layout used by the issue buffer and the ID1 stage.
package if_id_pkg;

  localparam int LANES_DEF  = 2;
  localparam int INST_W_DEF = 32;
  localparam int PC_W_DEF   = 8;

  localparam logic [31:0] NOP_INST = 32'h0;

  // Low bit of lane k inside a lane-concatenated field of width w per lane.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  // Bundle layout, LSB first: inst[], pc[], pc_branch[], pred[], lane_valid[], pc_next.
  function automatic int bnd_off_pc(input int l, input int iw);
    return l * iw;
  endfunction

  function automatic int bnd_off_pcb(input int l, input int iw, input int pw);
    return l * iw + l * pw;
  endfunction

  function automatic int bnd_off_pred(input int l, input int iw, input int pw);
    return l * iw + 2 * l * pw;
  endfunction

  function automatic int bnd_off_lv(input int l, input int iw, input int pw);
    return l * iw + 2 * l * pw + l;
  endfunction

  function automatic int bnd_off_pcn(input int l, input int iw, input int pw);
    return l * iw + 2 * l * pw + 2 * l;
  endfunction

  function automatic int bnd_width(input int l, input int iw, input int pw);
    return l * iw + 2 * l * pw + 2 * l + pw;
  endfunction

  localparam int BND_OFF_PC_DEF   = bnd_off_pc(LANES_DEF, INST_W_DEF);
  localparam int BND_OFF_PCB_DEF  = bnd_off_pcb(LANES_DEF, INST_W_DEF, PC_W_DEF);
  localparam int BND_OFF_PRED_DEF = bnd_off_pred(LANES_DEF, INST_W_DEF, PC_W_DEF);
  localparam int BND_OFF_LV_DEF   = bnd_off_lv(LANES_DEF, INST_W_DEF, PC_W_DEF);
  localparam int BND_OFF_PCN_DEF  = bnd_off_pcn(LANES_DEF, INST_W_DEF, PC_W_DEF);
  localparam int BND_W_DEF        = bnd_width(LANES_DEF, INST_W_DEF, PC_W_DEF);

endpackage

// File: rtl/if_id_issue_buffer_bundle_store.sv
// DEPTH x bundle register array: one write port, pointer-addressed read, clear-all.
// Write lands on the rising edge; read reflects stored state only.
module if_id_bundle_store #(
  parameter int DEPTH = 2,
  parameter int BW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [BW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [BW-1:0] rdata_o
);

  logic [BW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_issue_buffer.sv
// IF->ID1 bundle buffer: DEPTH-entry circular queue, 1-cycle enqueue-to-output latency.
// in_ready depends on occupancy only; a stalled head stays bit-stable; flush drops everything.
module if_id_issue_buffer
  import if_id_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_kill,
  input  logic [LANES*INST_W-1:0] in_inst,
  input  logic [LANES*PC_W-1:0]   in_pc,
  input  logic [LANES*PC_W-1:0]   in_pc_branch,
  input  logic [LANES-1:0]        in_pred,
  input  logic [PC_W-1:0]         in_pc_next,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [LANES*INST_W-1:0] out_inst,
  output logic [LANES*PC_W-1:0]   out_pc,
  output logic [LANES*PC_W-1:0]   out_pc_branch,
  output logic [LANES-1:0]        out_pred,
  output logic [PC_W-1:0]         out_pc_next,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int O_PC   = bnd_off_pc(LANES, INST_W);
  localparam int O_PCB  = bnd_off_pcb(LANES, INST_W, PC_W);
  localparam int O_PRED = bnd_off_pred(LANES, INST_W, PC_W);
  localparam int O_LV   = bnd_off_lv(LANES, INST_W, PC_W);
  localparam int O_PCN  = bnd_off_pcn(LANES, INST_W, PC_W);
  localparam int BW     = bnd_width(LANES, INST_W, PC_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq, deq;
  logic [BW-1:0]    wr_bundle, rd_bundle, head;

  assign in_ready  = count_q < FULL_CNT;
  assign out_valid = count_q != '0;
  assign count     = count_q;

  // An all-killed bundle carries nothing, so it never takes an entry.
  assign enq = in_valid && in_ready && !flush && (in_lane_kill != {LANES{1'b1}});
  assign deq = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic kill;
    assign kill = in_lane_kill[k];
    assign wr_bundle[lane_lo(k, INST_W) +: INST_W] =
      kill ? INST_W'(NOP_INST) : in_inst[lane_lo(k, INST_W) +: INST_W];
    assign wr_bundle[O_PC + lane_lo(k, PC_W) +: PC_W] =
      kill ? '0 : in_pc[lane_lo(k, PC_W) +: PC_W];
    assign wr_bundle[O_PCB + lane_lo(k, PC_W) +: PC_W] =
      kill ? '0 : in_pc_branch[lane_lo(k, PC_W) +: PC_W];
    assign wr_bundle[O_PRED + k] = !kill && in_pred[k];
    assign wr_bundle[O_LV + k]   = !kill;
  end
  assign wr_bundle[O_PCN +: PC_W] = in_pc_next;

  if_id_bundle_store #(
    .DEPTH (DEPTH),
    .BW    (BW)
  ) u_store (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .we_i    (enq),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_bundle),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_bundle)
  );

  // Dequeued slots keep old data; gating on occupancy keeps it off the outputs.
  assign head = out_valid ? rd_bundle : '0;

  assign out_inst       = head[0 +: LANES*INST_W];
  assign out_pc         = head[O_PC +: LANES*PC_W];
  assign out_pc_branch  = head[O_PCB +: LANES*PC_W];
  assign out_pred       = head[O_PRED +: LANES];
  assign out_lane_valid = head[O_LV +: LANES];
  assign out_pc_next    = head[O_PCN +: PC_W];

endmodule

// File: tb/tb_if_id_issue_buffer.sv
// Bench for if_id_issue_buffer: directed scenarios plus random traffic against a queue model.
module tb_if_id_issue_buffer;

  localparam int L  = 2;
  localparam int IW = 32;
  localparam int PW = 8;
  localparam int D  = 2;

  typedef struct packed {
    logic [L-1:0]    lv;
    logic [L*IW-1:0] inst;
    logic [L*PW-1:0] pc;
    logic [L*PW-1:0] pcb;
    logic [L-1:0]    pred;
    logic [PW-1:0]   pcn;
  } bnd_t;

  logic              clk, rst_n;
  logic              in_valid, in_ready, flush, out_valid, out_ready;
  logic [L-1:0]      in_lane_kill, in_pred, out_lane_valid, out_pred;
  logic [L*IW-1:0]   in_inst, out_inst;
  logic [L*PW-1:0]   in_pc, in_pc_branch, out_pc, out_pc_branch;
  logic [PW-1:0]     in_pc_next, out_pc_next;
  logic [$clog2(D):0] count;

  bnd_t exp_q[$];
  bnd_t pend;
  bit   pend_acc;
  bit   rst_next;
  int   n_tests, n_fail;

  if_id_issue_buffer #(.LANES(L), .INST_W(IW), .PC_W(PW), .DEPTH(D)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane_kill   (in_lane_kill),
    .in_inst        (in_inst),
    .in_pc          (in_pc),
    .in_pc_branch   (in_pc_branch),
    .in_pred        (in_pred),
    .in_pc_next     (in_pc_next),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pc_branch  (out_pc_branch),
    .out_pred       (out_pred),
    .out_pc_next    (out_pc_next),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // What the buffer must hold for the bundle currently on the inputs.
  function automatic bnd_t model_bundle();
    bnd_t b;
    b = '0;
    for (int k = 0; k < L; k++) begin
      if (!in_lane_kill[k]) begin
        b.lv[k]             = 1'b1;
        b.inst[k*IW +: IW]  = in_inst[k*IW +: IW];
        b.pc[k*PW +: PW]    = in_pc[k*PW +: PW];
        b.pcb[k*PW +: PW]   = in_pc_branch[k*PW +: PW];
        b.pred[k]           = in_pred[k];
      end
    end
    b.pcn = in_pc_next;
    return b;
  endfunction

  task automatic step(input bit v, input logic [L-1:0] kill, input logic [L-1:0] pred,
                      input bit fl, input bit rdy, input logic [PW-1:0] pc0);
    @(posedge clk);
    if (pend_acc) exp_q.push_back(pend);
    #1;
    rst_n        = rst_next;
    in_valid     = v;
    in_lane_kill = kill;
    in_pred      = pred;
    flush        = fl;
    out_ready    = rdy;
    for (int k = 0; k < L; k++) begin
      in_inst[k*IW +: IW]      = $urandom;
      in_pc[k*PW +: PW]        = pc0 + PW'(k);
      in_pc_branch[k*PW +: PW] = PW'($urandom);
    end
    in_pc_next = pc0 + PW'(L);
    pend       = model_bundle();
    pend_acc   = rst_n && v && !fl && (kill != {L{1'b1}}) && (exp_q.size() < D);
  endtask

  // Monitor: compare the visible head against the model, then retire what decode takes.
  always @(negedge clk) begin
    bnd_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q[0];
    chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(exp_q.size() < D));
    chk("count", 128'(count), 128'(exp_q.size()));
    chk("out_lane_valid", 128'(out_lane_valid), 128'(e.lv));
    chk("out_inst", 128'(out_inst), 128'(e.inst));
    chk("out_pc", 128'(out_pc), 128'(e.pc));
    chk("out_pc_branch", 128'(out_pc_branch), 128'(e.pcb));
    chk("out_pred", 128'(out_pred), 128'(e.pred));
    chk("out_pc_next", 128'(out_pc_next), 128'(e.pcn));
    if (rst_n && flush) exp_q.delete();
    else if (rst_n && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  initial begin
    n_tests = 0; n_fail = 0;
    pend_acc = 0; pend = '0;
    rst_n = 1'b1; rst_next = 1'b0;
    in_valid = 0; in_lane_kill = '0; in_pred = '0; flush = 0; out_ready = 0;
    in_inst = '0; in_pc = '0; in_pc_branch = '0; in_pc_next = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_count", 128'(count), 128'(0));

    // Single bundle, accepted on the first edge after reset release.
    rst_next = 1'b1;
    step(1, 2'b00, 2'b01, 0, 1, 8'h10);
    step(0, 2'b00, 2'b00, 0, 1, 8'h00);
    step(0, 2'b00, 2'b00, 0, 1, 8'h00);

    // Stall fill: A, B accepted, C held until space frees.
    step(1, 2'b00, 2'b10, 0, 0, 8'h20);
    step(1, 2'b00, 2'b01, 0, 0, 8'h30);
    step(1, 2'b00, 2'b11, 0, 0, 8'h40);
    step(1, 2'b00, 2'b11, 0, 0, 8'h40);
    step(1, 2'b00, 2'b11, 0, 1, 8'h40);
    step(1, 2'b00, 2'b11, 0, 1, 8'h40);
    repeat (3) step(0, 2'b00, 2'b00, 0, 1, 8'h00);

    // Kill masking, then a fully killed bundle.
    step(1, 2'b10, 2'b11, 0, 1, 8'h50);
    step(1, 2'b11, 2'b11, 0, 1, 8'h60);
    repeat (2) step(0, 2'b00, 2'b00, 0, 1, 8'h00);

    // Flush at full with a bundle presented, then a lone bundle.
    step(1, 2'b00, 2'b01, 0, 0, 8'h70);
    step(1, 2'b00, 2'b10, 0, 0, 8'h80);
    step(1, 2'b00, 2'b11, 1, 0, 8'h90);
    step(1, 2'b00, 2'b11, 0, 1, 8'hA0);
    repeat (2) step(0, 2'b00, 2'b00, 0, 1, 8'h00);

    // Steady enqueue+dequeue at occupancy 1 across pointer wrap.
    step(1, 2'b00, 2'b01, 0, 0, 8'hB0);
    for (int i = 0; i < 2*D+1; i++) step(1, 2'b00, 2'(i), 0, 1, 8'hC0 + 8'(i*4));
    repeat (2) step(0, 2'b00, 2'b00, 0, 1, 8'h00);

    // Asynchronous reset mid-stall at full.
    step(1, 2'b00, 2'b11, 0, 0, 8'hD0);
    step(1, 2'b00, 2'b11, 0, 0, 8'hE0);
    step(0, 2'b00, 2'b00, 0, 0, 8'h00);
    @(posedge clk);
    if (pend_acc) exp_q.push_back(pend);
    #3;
    rst_n = 1'b0; rst_next = 1'b0; pend_acc = 0; exp_q.delete();
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(1));
    chk("arst_out_pred", 128'(out_pred), 128'(0));
    chk("arst_count", 128'(count), 128'(0));
    step(0, 2'b00, 2'b00, 0, 0, 8'h00);
    rst_next = 1'b1;
    step(1, 2'b00, 2'b10, 0, 1, 8'hF0);
    repeat (2) step(0, 2'b00, 2'b00, 0, 1, 8'h00);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [L-1:0] kill;
      kill = ($urandom_range(0, 3) == 0) ? L'($urandom_range(0, 3)) : '0;
      step($urandom_range(0, 3) != 0, kill, L'($urandom_range(0, 3)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, PW'($urandom));
    end
    repeat (4) step(0, 2'b00, 2'b00, 0, 1, 8'h00);

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
